bicubic_coord_gen: RTL and testbench



---
 rtl/bicubic_coord_gen_pkg.sv | 26 ++
 rtl/bicubic_coord_gen_if.sv | 25 ++
 rtl/bicubic_coord_gen_axis.sv | 51 +++++
 rtl/bicubic_coord_gen.sv | 121 ++++++++++++
 tb/tb_bicubic_coord_gen.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bicubic_coord_gen_pkg.sv
// Shared constants, FSM encoding and initial-phase helper for the bicubic
// coordinate generator and its weight-generator consumer.
package bicubic_coord_gen_pkg;
    localparam int DIM_W  = 12;
    localparam int FRAC_W = 8;
    localparam int ACC_W  = 24;
    localparam int STEP_W = DIM_W + FRAC_W;
    localparam int ONE_Q  = 256;
    localparam int HALF_Q = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Centre-aligned starting phase: step/2 - 0.5, never below zero.
    function automatic logic [ACC_W-1:0] init_phase(input logic [STEP_W-1:0] step);
        logic [STEP_W-1:0] half;
        half = step >> 1;
        if (half < STEP_W'(HALF_Q))
            return '0;
        else
            return ACC_W'(half - STEP_W'(HALF_Q));
    endfunction
endpackage

// File: rtl/bicubic_coord_gen_if.sv
// Coordinate beat stream from the generator (master) to the weight generator (slave).
// Handshake: a beat transfers on a cycle with out_valid & out_ready; once out_valid
// is high it stays high and every payload field holds until that transfer.
interface bicubic_coord_gen_if;
    import bicubic_coord_gen_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [DIM_W-1:0] src_x;
    logic [DIM_W-1:0] src_y;
    logic [8:0]       xBlend;
    logic [8:0]       yBlend;
    logic             line_last;
    logic             frame_last;

    modport master (
        output out_valid, src_x, src_y, xBlend, yBlend, line_last, frame_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, src_x, src_y, xBlend, yBlend, line_last, frame_last,
        output out_ready
    );
endinterface

// File: rtl/bicubic_coord_gen_axis.sv
// One axis of the coordinate walk: Q16.8 saturating accumulator plus the
// registered clamp/split into integer source coordinate and 8-bit blend.
module bicubic_axis_acc
    import bicubic_coord_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_init,
    input  logic              advance,
    input  logic [STEP_W-1:0] step,
    input  logic [DIM_W-1:0]  src_dim,
    output logic [DIM_W-1:0]  coord,
    output logic [8:0]        blend
);
    localparam int INT_W = ACC_W - FRAC_W;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W:0]   sum;
    logic [INT_W-1:0] ipart;
    logic [INT_W-1:0] imax;

    always_comb begin
        sum      = {1'b0, acc} + (ACC_W+1)'(step);
        acc_next = acc;
        if (load_init)
            acc_next = init_phase(step);
        else if (advance)
            acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        ipart = acc_next[ACC_W-1:FRAC_W];
        imax  = INT_W'(src_dim) - INT_W'(1);
    end

    // Outputs are derived from acc_next so they line up with the register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            coord <= '0;
            blend <= '0;
        end else begin
            acc <= acc_next;
            if (ipart >= imax) begin
                coord <= imax[DIM_W-1:0];
                blend <= '0;
            end else begin
                coord <= ipart[DIM_W-1:0];
                blend <= {1'b0, acc_next[FRAC_W-1:0]};
            end
        end
    end
endmodule

// File: rtl/bicubic_coord_gen.sv
// Raster walk over the destination frame, emitting source coordinates and
// Q8 blend phases for each output pixel through a valid/ready stream.
module bicubic_coord_gen
    import bicubic_coord_gen_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DIM_W-1:0]    cfg_src_w,
    input  logic [DIM_W-1:0]    cfg_src_h,
    input  logic [DIM_W-1:0]    cfg_dst_w,
    input  logic [DIM_W-1:0]    cfg_dst_h,
    input  logic [STEP_W-1:0]   cfg_step_x,
    input  logic [STEP_W-1:0]   cfg_step_y,
    bicubic_coord_gen_if.master beat,
    output logic                busy,
    output logic                done,
    output state_t              dbg_state
);
    state_t state, state_next;

    logic [DIM_W-1:0]  src_w_q, src_h_q, dst_w_q, dst_h_q;
    logic [STEP_W-1:0] step_x_q, step_y_q;
    logic [DIM_W-1:0]  dst_x, dst_y;
    logic              valid_q;
    logic              load, dims_ok, accept, row_end, last_row;
    logic [DIM_W-1:0]  sx, sy;
    logic [8:0]        bx, by;

    assign load     = (state == ST_IDLE) && start;
    assign dims_ok  = (|cfg_dst_w) && (|cfg_dst_h);
    assign accept   = valid_q && beat.out_ready;
    assign row_end  = (dst_x == dst_w_q - DIM_W'(1));
    assign last_row = (dst_y == dst_h_q - DIM_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = dims_ok ? ST_RUN : ST_DONE;
            ST_RUN:  if (accept && row_end && last_row) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_w_q  <= '0;
            src_h_q  <= '0;
            dst_w_q  <= '0;
            dst_h_q  <= '0;
            step_x_q <= '0;
            step_y_q <= '0;
            dst_x    <= '0;
            dst_y    <= '0;
            valid_q  <= 1'b0;
        end else if (load) begin
            src_w_q  <= cfg_src_w;
            src_h_q  <= cfg_src_h;
            dst_w_q  <= cfg_dst_w;
            dst_h_q  <= cfg_dst_h;
            step_x_q <= cfg_step_x;
            step_y_q <= cfg_step_y;
            dst_x    <= '0;
            dst_y    <= '0;
            valid_q  <= dims_ok;
        end else if (accept) begin
            if (row_end) begin
                dst_x <= '0;
                dst_y <= dst_y + DIM_W'(1);
                if (last_row) valid_q <= 1'b0;
            end else begin
                dst_x <= dst_x + DIM_W'(1);
            end
        end
    end

    // In the start cycle the shadows are not loaded yet, so the first beat uses cfg_* directly.
    bicubic_axis_acc u_axis_x (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_init (load || (accept && row_end)),
        .advance   (accept && !row_end),
        .step      (load ? cfg_step_x : step_x_q),
        .src_dim   (load ? cfg_src_w : src_w_q),
        .coord     (sx),
        .blend     (bx)
    );

    bicubic_axis_acc u_axis_y (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_init (load),
        .advance   (accept && row_end),
        .step      (load ? cfg_step_y : step_y_q),
        .src_dim   (load ? cfg_src_h : src_h_q),
        .coord     (sy),
        .blend     (by)
    );

    assign beat.out_valid  = valid_q;
    assign beat.src_x      = sx;
    assign beat.src_y      = sy;
    assign beat.xBlend     = bx;
    assign beat.yBlend     = by;
    assign beat.line_last  = valid_q && row_end;
    assign beat.frame_last = valid_q && row_end && last_row;
endmodule

// File: tb/tb_bicubic_coord_gen.sv
// Directed bench for bicubic_coord_gen: frame-level model, stream scoreboard,
// literal spot checks, backpressure, empty frame, start-ignore and reset cases.
module tb_bicubic_coord_gen;
    import bicubic_coord_gen_pkg::*;

    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  cfg_src_w = '0, cfg_src_h = '0, cfg_dst_w = '0, cfg_dst_h = '0;
    logic [STEP_W-1:0] cfg_step_x = '0, cfg_step_y = '0;
    logic              busy, done;
    state_t            dbg_state;

    bicubic_coord_gen_if bus();

    bicubic_coord_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_src_w  (cfg_src_w),
        .cfg_src_h  (cfg_src_h),
        .cfg_dst_w  (cfg_dst_w),
        .cfg_dst_h  (cfg_dst_h),
        .cfg_step_x (cfg_step_x),
        .cfg_step_y (cfg_step_y),
        .beat       (bus),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    logic [43:0] exp_q[$];
    int got_x[$];
    int got_b[$];
    int done_cnt = 0;
    int done_base = 0;
    int last_done_cyc = 0;
    int cyc_start = 0;
    int acc_cnt = 0;
    int n_exp = 0;
    bit rand_ready = 1'b0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic longint init_of(input int step);
        return (step / 2 >= HALF_Q) ? longint'(step / 2 - HALF_Q) : 64'sd0;
    endfunction

    task automatic split(input longint a, input int src, output int c, output int b);
        longint ix;
        ix = a / ONE_Q;
        if (ix >= longint'(src - 1)) begin
            c = src - 1;
            b = 0;
        end else begin
            c = int'(ix);
            b = int'(a % ONE_Q);
        end
    endtask

    task automatic build_model(input int sw, input int sh, input int dw, input int dh,
                               input int stx, input int sty);
        longint ax, ay;
        int cx, bx, cy, by;
        bit ll, fl;
        for (int y = 0; y < dh; y++) begin
            for (int x = 0; x < dw; x++) begin
                ax = init_of(stx) + longint'(x) * stx;
                ay = init_of(sty) + longint'(y) * sty;
                if (ax > ACC_MAX) ax = ACC_MAX;
                if (ay > ACC_MAX) ay = ACC_MAX;
                split(ax, sw, cx, bx);
                split(ay, sh, cy, by);
                ll = (x == dw - 1);
                fl = ll && (y == dh - 1);
                exp_q.push_back({12'(cx), 12'(cy), 9'(bx), 9'(by), ll, fl});
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic launch(input int sw, input int sh, input int dw, input int dh,
                          input int stx, input int sty);
        @(posedge clk);
        #1;
        cfg_src_w  = 12'(sw);
        cfg_src_h  = 12'(sh);
        cfg_dst_w  = 12'(dw);
        cfg_dst_h  = 12'(dh);
        cfg_step_x = 20'(stx);
        cfg_step_y = 20'(sty);
        got_x.delete();
        got_b.delete();
        build_model(sw, sh, dw, dh, stx, sty);
        n_exp     = dw * dh;
        done_base = done_cnt;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        cyc_start = cyc;
        // Scramble cfg: the running frame must keep using its latched copy.
        cfg_src_w  = 12'($urandom_range(1, 4095));
        cfg_src_h  = 12'($urandom_range(1, 4095));
        cfg_dst_w  = 12'($urandom_range(0, 4095));
        cfg_dst_h  = 12'($urandom_range(0, 4095));
        cfg_step_x = 20'($urandom_range(0, 1048575));
        cfg_step_y = 20'($urandom_range(0, 1048575));
    endtask

    task automatic wait_frame(input bit timed);
        int t;
        t = 0;
        while (done_cnt == done_base && t < 600) begin
            @(negedge clk);
            t++;
        end
        check(done_cnt != done_base, "frame_timeout", 64'(t), 64'(600));
        if (timed)
            check(last_done_cyc - cyc_start == n_exp, "done_latency",
                  64'(last_done_cyc - cyc_start), 64'(n_exp));
        repeat (3) @(negedge clk);
        check(done_cnt - done_base == 1, "done_count", 64'(done_cnt - done_base), 64'd1);
        check(exp_q.size() == 0, "beats_missing", 64'(exp_q.size()), 64'd0);
        check(!bus.out_valid && !busy && dbg_state == ST_IDLE, "idle_after_frame",
              {62'd0, bus.out_valid, busy}, 64'd0);
    endtask

    task automatic lit_check(input string nm, input int n, input int ex[4], input int eb[4]);
        for (int i = 0; i < n; i++) begin
            if (got_x.size() > i)
                check(got_x[i] == ex[i] && got_b[i] == eb[i], nm,
                      {32'(got_x[i]), 32'(got_b[i])}, {32'(ex[i]), 32'(eb[i])});
            else
                check(1'b0, nm, 64'(got_x.size()), 64'(n));
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    initial begin
        logic [43:0] cur, prev, e;
        bit hold, exp_done;
        hold = 1'b0;
        exp_done = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
                exp_done = 1'b0;
            end else begin
                cur = {bus.src_x, bus.src_y, bus.xBlend, bus.yBlend, bus.line_last, bus.frame_last};
                if (hold)
                    check(bus.out_valid && cur == prev, "hold_stable",
                          {19'd0, bus.out_valid, cur}, {19'd0, 1'b1, prev});
                if (exp_done)
                    check(done, "done_after_last", 64'(done), 64'd1);
                exp_done = 1'b0;
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                end
                if (bus.out_valid && bus.out_ready) begin
                    acc_cnt++;
                    got_x.push_back(int'(bus.src_x));
                    got_b.push_back(int'(bus.xBlend));
                    check(exp_q.size() != 0, "extra_beat", 64'(cur), 64'd0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check(cur == e, "beat", 64'(cur), 64'(e));
                    end
                    if (bus.frame_last) exp_done = 1'b1;
                end
                hold = bus.out_valid && !bus.out_ready;
                prev = cur;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        check(!bus.out_valid && !busy && !done && dbg_state == ST_IDLE, "reset_ctrl",
              {61'd0, bus.out_valid, busy, done}, 64'd0);
        check({bus.src_x, bus.src_y, bus.xBlend, bus.yBlend, bus.line_last, bus.frame_last} == '0,
              "reset_data", 64'({bus.src_x, bus.src_y, bus.xBlend, bus.yBlend}), 64'd0);
        rst_n = 1'b1;

        // identity 4x4
        launch(4, 4, 4, 4, 256, 256);
        wait_frame(1'b1);
        lit_check("identity_row0", 4, '{0, 1, 2, 3}, '{0, 0, 0, 0});

        // 2x upscale, init clamps to 0
        launch(2, 2, 4, 4, 128, 128);
        wait_frame(1'b1);
        lit_check("upscale_row0", 4, '{0, 0, 1, 1}, '{0, 128, 0, 0});

        // downscale with clamp
        launch(4, 1, 3, 1, 384, 256);
        wait_frame(1'b1);
        lit_check("down384", 3, '{0, 1, 3, 0}, '{64, 192, 0, 0});
        launch(4, 1, 2, 1, 512, 256);
        wait_frame(1'b1);
        lit_check("down512", 2, '{0, 2, 0, 0}, '{128, 128, 0, 0});

        // accumulator saturation at the top of Q16.8
        launch(4095, 1, 20, 1, 1048575, 256);
        wait_frame(1'b1);
        lit_check("saturate", 2, '{2047, 4094, 0, 0}, '{127, 0, 0, 0});

        // backpressure
        rand_ready = 1'b1;
        launch(4, 4, 4, 4, 256, 256);
        wait_frame(1'b0);
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);

        // empty frame
        launch(4, 4, 0, 4, 256, 256);
        wait_frame(1'b1);

        // second start mid-frame is ignored
        launch(4, 4, 4, 4, 256, 256);
        repeat (5) @(posedge clk);
        #1;
        cfg_dst_w = 12'd2;
        cfg_dst_h = 12'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_frame(1'b1);

        // asynchronous reset mid-frame
        acc_cnt = 0;
        launch(4, 4, 4, 4, 256, 256);
        t = 0;
        while (acc_cnt < 5 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(acc_cnt >= 5, "reset_wait", 64'(acc_cnt), 64'd5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check(!bus.out_valid && !busy && dbg_state == ST_IDLE, "reset_midframe",
              {62'd0, bus.out_valid, busy}, 64'd0);
        exp_q.delete();
        done_base = done_cnt;
        repeat (3) @(negedge clk);
        check(done_cnt == done_base && !done, "no_done_on_reset", 64'(done_cnt - done_base), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        launch(4, 4, 4, 4, 256, 256);
        wait_frame(1'b1);
        lit_check("restart_row0", 4, '{0, 1, 2, 3}, '{0, 0, 0, 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
